writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- MEM/WB pipeline register plus write-back datapath of the 5-stage MIPS core.
- Captures MEM-stage results, selects ALU, load or link data, and sign/zero-aligns sub-word loads.
- Drives the register file write port (REG_write_1, REG_address_wr, REG_data_wb_in1).
- Also exports forwarding info, an alignment-fault pulse and a retired-instruction counter.

Parameters:
- DATA_W, 32, datapath width.
- ADDR_W, 5, register address width.
- CNT_W, 32, retired-instruction counter width.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- clk_reset  in  1  synchronous reset, active-high.
- MEM_valid  in  1  MEM stage holds a real instruction.
- MEM_reg_write  in  1  instruction writes a GPR.
- MEM_rd  in  ADDR_W  destination register.
- MEM_wb_sel  in  2  source select: 0 ALU, 1 load, 2 link, 3 reserved.
- MEM_load_type  in  3  0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU; others reserved.
- MEM_byte_off  in  2  effective address [1:0].
- MEM_alu_result  in  DATA_W  ALU result.
- MEM_rdata  in  DATA_W  raw data-memory word.
- MEM_pc  in  DATA_W  instruction PC.
- WB_stall  in  1  hold the stage register.
- WB_flush  in  1  replace captured instruction with a bubble.
- REG_write_1  out  1  register-file write enable.
- REG_address_wr  out  ADDR_W  register-file write address.
- REG_data_wb_in1  out  DATA_W  register-file write data.
- WB_fwd_valid  out  1  forwarding entry valid; equals REG_write_1.
- WB_align_err  out  1  one-cycle misaligned-load pulse.
- WB_retired  out  CNT_W  count of retired instructions.

Behaviour:
- Reset: clk_reset high at a rising edge clears stage register, valid, all outputs and WB_retired to 0. Applies mid-stall or mid-flush; reset has top priority.
- Capture priority per edge: reset > WB_flush > WB_stall > normal.
  - Flush: valid <= 0 and reg_write <= 0; other fields don't-care.
  - Stall: all stage fields hold.
  - Normal: all MEM_* inputs are captured.
- Latency: MEM inputs at edge N drive outputs from edge N until edge N+1. Outputs are combinational from the stage register only; no MEM_* input reaches an output combinationally.
- Data select on registered fields:
  - wb_sel 0: alu_result.
  - wb_sel 1: aligned load.
  - wb_sel 2: pc + 8 (modulo 2^DATA_W).
  - wb_sel 3: 0, with the write suppressed.
- Load alignment is big-endian; byte k at bits [31-8k -: 8].
  - LB/LBU select byte at byte_off; LB sign-extends, LBU zero-extends.
  - LH/LHU select half at byte_off[1] (0 = upper half); LH sign-extends, LHU zero-extends.
  - LW passes the word through.
  - Reserved load_type: treated as misaligned.
- Misalignment: LH/LHU with byte_off[0]=1, or LW with byte_off != 0, while valid and wb_sel=1.
  - Write is suppressed.
  - WB_align_err is 1 for exactly the cycles that instruction is held; a stalled instance stays high while held.
- REG_write_1 = valid & reg_write & (rd != 0) & ~misaligned & (wb_sel != 3).
  - Writes to $0 never leave the block.
  - REG_address_wr and REG_data_wb_in1 are 0 when REG_write_1 = 0.
- WB_retired increments by 1 on each edge where the stage holds a valid instruction and is not stalled. Flushed bubbles and misaligned loads still count if valid. Wraps from all-ones to 0.
- Simultaneous WB_stall and WB_flush: flush wins.

Decomposition:
- Shared package core_pkg holds:
  - wb_sel encodings WB_ALU, WB_LOAD, WB_LINK.
  - load_type encodings LT_LW, LT_LH, LT_LHU, LT_LB, LT_LBU.
  - LINK_OFFSET = 8.
- One sub-module, load_align: purely combinational. Takes rdata, load_type and byte_off; returns aligned data and the misaligned flag.
- All sequential state (stage register, counter) stays in writeback_stage.

Test Plan:
- Reset: clk_reset=1 for 2 cycles with MEM_valid=1 → REG_write_1=0, REG_data_wb_in1=0, WB_retired=0. After release, one ALU op (rd=3, alu=0x0000_1234) gives REG_write_1=1, addr=3, data=0x0000_1234 the next cycle, and WB_retired=1.
- Loads on rdata=0x80F1_7F22:
  - LB off=1 → 0xFFFF_FFF1.
  - LBU off=1 → 0x0000_00F1.
  - LH off=0 → 0xFFFF_80F1.
  - LHU off=2 → 0x0000_7F22.
  - LW off=0 → 0x80F1_7F22.
- Misaligned: LW off=2, then LH off=3 → REG_write_1=0 and WB_align_err=1 for one cycle each; the counter still increments.
- Link and $0: wb_sel=2, pc=0xFFFF_FFFC, rd=31 → data 0x0000_0004. Same op with rd=0 → REG_write_1=0.
- Stall/flush: stall 3 cycles with ALU op rd=5 held → outputs constant and WB_retired unchanged. Stall+flush together → bubble, REG_write_1=0 next cycle.
- Counter wrap: preload via 2^CNT_W-1 retirements (CNT_W=4 build, 15 ops), one more → WB_retired=0.

Source files
------------

// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared encodings for the MIPS core pipeline.
//   wb_sel_e    : write-back source select carried from MEM into WB
//   load_type_e : memory load width/sign encoding
//   LINK_OFFSET : link-register value is PC plus this offset (delay slot)
// ---------------------------------------------------------------------------
package core_pkg;

   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_LOAD = 2'd1,
      WB_LINK = 2'd2,
      WB_RSVD = 2'd3
   } wb_sel_e;

   typedef enum logic [2:0] {
      LT_LW  = 3'd0,
      LT_LH  = 3'd1,
      LT_LHU = 3'd2,
      LT_LB  = 3'd3,
      LT_LBU = 3'd4
   } load_type_e;

   localparam int LINK_OFFSET = 8;

endpackage : core_pkg

// File: rtl/writeback_stage_load_align.sv
// ---------------------------------------------------------------------------
// load_align
// Purely combinational big-endian load aligner. Byte k of the word sits at
// bits [DATA_W-1-8k -: 8]; half 0 is the upper half.
// Ports:
//   rdata      in  raw data-memory word
//   load_type  in  load encoding (reserved values flag misaligned)
//   byte_off   in  effective address [1:0]
//   data       out aligned, sign/zero-extended load data
//   misaligned out access not naturally aligned for its width
// ---------------------------------------------------------------------------
module load_align
   import core_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] rdata,
   input  load_type_e        load_type,
   input  logic [1:0]        byte_off,
   output logic [DATA_W-1:0] data,
   output logic              misaligned
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Pick the addressed byte/half, then extend according to load type.
   always_comb begin
      byte_s     = 8'h00;
      half_s     = 16'h0000;
      data       = {DATA_W{1'b0}};
      misaligned = 1'b0;

      case (byte_off)
         2'd0:    byte_s = rdata[DATA_W-1  -: 8];
         2'd1:    byte_s = rdata[DATA_W-9  -: 8];
         2'd2:    byte_s = rdata[DATA_W-17 -: 8];
         2'd3:    byte_s = rdata[DATA_W-25 -: 8];
         default: byte_s = 8'h00;
      endcase

      if (byte_off[1] == 1'b0) begin
         half_s = rdata[DATA_W-1 -: 16];
      end else begin
         half_s = rdata[DATA_W-17 -: 16];
      end

      case (load_type)
         LT_LW: begin
            data       = rdata;
            misaligned = (byte_off != 2'd0);
         end
         LT_LH: begin
            data       = {{(DATA_W-16){half_s[15]}}, half_s};
            misaligned = byte_off[0];
         end
         LT_LHU: begin
            data       = {{(DATA_W-16){1'b0}}, half_s};
            misaligned = byte_off[0];
         end
         LT_LB: begin
            data       = {{(DATA_W-8){byte_s[7]}}, byte_s};
            misaligned = 1'b0;
         end
         LT_LBU: begin
            data       = {{(DATA_W-8){1'b0}}, byte_s};
            misaligned = 1'b0;
         end
         default: begin
            // Reserved encodings never write; reported as an alignment fault.
            data       = {DATA_W{1'b0}};
            misaligned = 1'b1;
         end
      endcase
   end

endmodule : load_align

// File: rtl/writeback_stage.sv
// ---------------------------------------------------------------------------
// writeback_stage
// MEM/WB pipeline register plus write-back datapath.
// Ports:
//   clk, clk_reset            clock, synchronous active-high reset
//   MEM_*                     instruction fields from the MEM stage
//   WB_stall / WB_flush       hold the stage / replace it with a bubble
//   REG_write_1, REG_address_wr, REG_data_wb_in1
//                             register-file write port (address/data are 0
//                             whenever no write happens)
//   WB_fwd_valid              forwarding entry valid (same as REG_write_1)
//   WB_align_err              high while a misaligned load is held in WB
//   WB_retired                retired-instruction counter (wraps)
// Outputs depend only on the stage register, never on MEM_* directly.
// ---------------------------------------------------------------------------
module writeback_stage
   import core_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              clk_reset,
   input  logic              MEM_valid,
   input  logic              MEM_reg_write,
   input  logic [ADDR_W-1:0] MEM_rd,
   input  logic [1:0]        MEM_wb_sel,
   input  logic [2:0]        MEM_load_type,
   input  logic [1:0]        MEM_byte_off,
   input  logic [DATA_W-1:0] MEM_alu_result,
   input  logic [DATA_W-1:0] MEM_rdata,
   input  logic [DATA_W-1:0] MEM_pc,
   input  logic              WB_stall,
   input  logic              WB_flush,
   output logic              REG_write_1,
   output logic [ADDR_W-1:0] REG_address_wr,
   output logic [DATA_W-1:0] REG_data_wb_in1,
   output logic              WB_fwd_valid,
   output logic              WB_align_err,
   output logic [CNT_W-1:0]  WB_retired
);

   logic              valid_r;
   logic              reg_write_r;
   logic [ADDR_W-1:0] rd_r;
   wb_sel_e           wb_sel_r;
   load_type_e        load_type_r;
   logic [1:0]        byte_off_r;
   logic [DATA_W-1:0] alu_result_r;
   logic [DATA_W-1:0] rdata_r;
   logic [DATA_W-1:0] pc_r;
   logic [CNT_W-1:0]  retired_r;

   logic [DATA_W-1:0] load_data_s;
   logic              load_mis_s;
   logic              align_err_s;
   logic              write_s;
   logic [DATA_W-1:0] sel_data_s;

   // Stage register: reset > flush > stall > capture.
   always_ff @(posedge clk) begin
      if (clk_reset) begin
         valid_r      <= 1'b0;
         reg_write_r  <= 1'b0;
         rd_r         <= {ADDR_W{1'b0}};
         wb_sel_r     <= WB_ALU;
         load_type_r  <= LT_LW;
         byte_off_r   <= 2'd0;
         alu_result_r <= {DATA_W{1'b0}};
         rdata_r      <= {DATA_W{1'b0}};
         pc_r         <= {DATA_W{1'b0}};
      end else if (WB_flush) begin
         // Only the qualifiers matter for a bubble; data fields are left as-is.
         valid_r     <= 1'b0;
         reg_write_r <= 1'b0;
      end else if (!WB_stall) begin
         valid_r      <= MEM_valid;
         reg_write_r  <= MEM_reg_write;
         rd_r         <= MEM_rd;
         wb_sel_r     <= wb_sel_e'(MEM_wb_sel);
         load_type_r  <= load_type_e'(MEM_load_type);
         byte_off_r   <= MEM_byte_off;
         alu_result_r <= MEM_alu_result;
         rdata_r      <= MEM_rdata;
         pc_r         <= MEM_pc;
      end
   end

   // Retired counter: the held instruction retires on any non-stalled edge.
   always_ff @(posedge clk) begin
      if (clk_reset) begin
         retired_r <= {CNT_W{1'b0}};
      end else if (valid_r && !WB_stall) begin
         retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   load_align #(
      .DATA_W (DATA_W)
   ) u_load_align (
      .rdata      (rdata_r),
      .load_type  (load_type_r),
      .byte_off   (byte_off_r),
      .data       (load_data_s),
      .misaligned (load_mis_s)
   );

   // Write-enable qualification, source select and zeroing of the write port.
   always_comb begin
      align_err_s = valid_r && (wb_sel_r == WB_LOAD) && load_mis_s;
      write_s     = valid_r && reg_write_r && (rd_r != {ADDR_W{1'b0}})
                    && !align_err_s && (wb_sel_r != WB_RSVD);
      sel_data_s  = {DATA_W{1'b0}};

      case (wb_sel_r)
         WB_ALU:  sel_data_s = alu_result_r;
         WB_LOAD: sel_data_s = load_data_s;
         WB_LINK: sel_data_s = pc_r + DATA_W'(LINK_OFFSET);
         default: sel_data_s = {DATA_W{1'b0}};
      endcase

      if (write_s) begin
         REG_address_wr  = rd_r;
         REG_data_wb_in1 = sel_data_s;
      end else begin
         REG_address_wr  = {ADDR_W{1'b0}};
         REG_data_wb_in1 = {DATA_W{1'b0}};
      end

      REG_write_1  = write_s;
      WB_fwd_valid = write_s;
      WB_align_err = align_err_s;
   end

   assign WB_retired = retired_r;

endmodule : writeback_stage

// File: tb/tb_writeback_stage.sv
// ---------------------------------------------------------------------------
// tb_writeback_stage
// Directed bench for writeback_stage. A behavioural model of the stage is
// compared against the DUT on every falling edge; literal expectations for
// the documented vectors pin the model. A second instance with a 4-bit
// counter exercises wrap-around.
// ---------------------------------------------------------------------------
module tb_writeback_stage;

   logic        clk;
   logic        clk_reset;
   logic        MEM_valid;
   logic        MEM_reg_write;
   logic [4:0]  MEM_rd;
   logic [1:0]  MEM_wb_sel;
   logic [2:0]  MEM_load_type;
   logic [1:0]  MEM_byte_off;
   logic [31:0] MEM_alu_result;
   logic [31:0] MEM_rdata;
   logic [31:0] MEM_pc;
   logic        WB_stall;
   logic        WB_flush;

   logic        REG_write_1;
   logic [4:0]  REG_address_wr;
   logic [31:0] REG_data_wb_in1;
   logic        WB_fwd_valid;
   logic        WB_align_err;
   logic [31:0] WB_retired;

   logic        w4_write;
   logic [4:0]  w4_addr;
   logic [31:0] w4_data;
   logic        w4_fwd;
   logic        w4_err;
   logic [3:0]  w4_retired;

   int checks = 0;
   int errors = 0;
   logic chk_en = 1'b0;

   writeback_stage dut (
      .clk(clk), .clk_reset(clk_reset),
      .MEM_valid(MEM_valid), .MEM_reg_write(MEM_reg_write), .MEM_rd(MEM_rd),
      .MEM_wb_sel(MEM_wb_sel), .MEM_load_type(MEM_load_type),
      .MEM_byte_off(MEM_byte_off), .MEM_alu_result(MEM_alu_result),
      .MEM_rdata(MEM_rdata), .MEM_pc(MEM_pc),
      .WB_stall(WB_stall), .WB_flush(WB_flush),
      .REG_write_1(REG_write_1), .REG_address_wr(REG_address_wr),
      .REG_data_wb_in1(REG_data_wb_in1), .WB_fwd_valid(WB_fwd_valid),
      .WB_align_err(WB_align_err), .WB_retired(WB_retired)
   );

   writeback_stage #(.CNT_W(4)) dut4 (
      .clk(clk), .clk_reset(clk_reset),
      .MEM_valid(MEM_valid), .MEM_reg_write(MEM_reg_write), .MEM_rd(MEM_rd),
      .MEM_wb_sel(MEM_wb_sel), .MEM_load_type(MEM_load_type),
      .MEM_byte_off(MEM_byte_off), .MEM_alu_result(MEM_alu_result),
      .MEM_rdata(MEM_rdata), .MEM_pc(MEM_pc),
      .WB_stall(WB_stall), .WB_flush(WB_flush),
      .REG_write_1(w4_write), .REG_address_wr(w4_addr),
      .REG_data_wb_in1(w4_data), .WB_fwd_valid(w4_fwd),
      .WB_align_err(w4_err), .WB_retired(w4_retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic        m_valid, m_rw;
   logic [4:0]  m_rd;
   logic [1:0]  m_sel, m_off;
   logic [2:0]  m_lt;
   logic [31:0] m_alu, m_rdata, m_pc;
   int unsigned m_cnt;

   always @(posedge clk) begin
      if (clk_reset) begin
         m_valid <= 1'b0; m_rw <= 1'b0; m_rd <= 5'd0; m_sel <= 2'd0;
         m_off <= 2'd0; m_lt <= 3'd0; m_alu <= 32'd0; m_rdata <= 32'd0;
         m_pc <= 32'd0; m_cnt <= 0;
      end else begin
         if (m_valid && !WB_stall) m_cnt <= m_cnt + 1;
         if (WB_flush) begin
            m_valid <= 1'b0; m_rw <= 1'b0;
         end else if (!WB_stall) begin
            m_valid <= MEM_valid; m_rw <= MEM_reg_write; m_rd <= MEM_rd;
            m_sel <= MEM_wb_sel; m_off <= MEM_byte_off; m_lt <= MEM_load_type;
            m_alu <= MEM_alu_result; m_rdata <= MEM_rdata; m_pc <= MEM_pc;
         end
      end
   end

   // Expected outputs from the model, checked every falling edge.
   logic [31:0] e_ld, e_part, e_data;
   logic        e_bad, e_err, e_we;
   int          sh;
   always @(negedge clk) begin
      if (chk_en) begin
         e_bad = 1'b0;
         e_ld  = 32'd0;
         if (m_lt == 3'd0) begin
            e_bad = (m_off != 2'd0);
            e_ld  = m_rdata;
         end else if (m_lt == 3'd1 || m_lt == 3'd2) begin
            e_bad  = m_off[0];
            sh     = m_off[1] ? 0 : 16;
            e_part = (m_rdata >> sh) & 32'h0000_FFFF;
            e_ld   = (m_lt == 3'd1 && e_part[15]) ? (e_part | 32'hFFFF_0000) : e_part;
         end else if (m_lt == 3'd3 || m_lt == 3'd4) begin
            sh     = 8 * (3 - int'(m_off));
            e_part = (m_rdata >> sh) & 32'h0000_00FF;
            e_ld   = (m_lt == 3'd3 && e_part[7]) ? (e_part | 32'hFFFF_FF00) : e_part;
         end else begin
            e_bad = 1'b1;
         end
         e_err = m_valid && (m_sel == 2'd1) && e_bad;
         e_we  = m_valid && m_rw && (m_rd != 5'd0) && !e_err && (m_sel != 2'd3);
         if (!e_we)              e_data = 32'd0;
         else if (m_sel == 2'd0) e_data = m_alu;
         else if (m_sel == 2'd1) e_data = e_ld;
         else                    e_data = m_pc + 32'd8;

         chk("m_we",      {31'd0, REG_write_1},  {31'd0, e_we});
         chk("m_fwd",     {31'd0, WB_fwd_valid}, {31'd0, e_we});
         chk("m_addr",    {27'd0, REG_address_wr}, e_we ? {27'd0, m_rd} : 32'd0);
         chk("m_data",    REG_data_wb_in1, e_data);
         chk("m_err",     {31'd0, WB_align_err}, {31'd0, e_err});
         chk("m_retired", WB_retired, m_cnt);
         chk("m_ret4",    {28'd0, w4_retired}, m_cnt & 32'hF);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic op(input logic v, input logic rw, input logic [4:0] rd,
                     input logic [1:0] sel, input logic [2:0] lt, input logic [1:0] off,
                     input logic [31:0] alu, input logic [31:0] rdata, input logic [31:0] pc);
      MEM_valid = v; MEM_reg_write = rw; MEM_rd = rd; MEM_wb_sel = sel;
      MEM_load_type = lt; MEM_byte_off = off; MEM_alu_result = alu;
      MEM_rdata = rdata; MEM_pc = pc; WB_stall = 1'b0; WB_flush = 1'b0;
      @(negedge clk);
   endtask

   task automatic ld(input logic [2:0] lt, input logic [1:0] off, input logic [31:0] exp,
                     input string nm);
      op(1'b1, 1'b1, 5'd4, 2'd1, lt, off, 32'hDEAD_BEEF, 32'h80F1_7F22, 32'd0);
      chk(nm, REG_data_wb_in1, exp);
      chk({nm, "_we"}, {31'd0, REG_write_1}, 32'd1);
   endtask

   initial begin
      clk_reset = 1'b1;
      MEM_valid = 1'b1; MEM_reg_write = 1'b1; MEM_rd = 5'd3; MEM_wb_sel = 2'd0;
      MEM_load_type = 3'd0; MEM_byte_off = 2'd0; MEM_alu_result = 32'h0000_1234;
      MEM_rdata = 32'd0; MEM_pc = 32'd0; WB_stall = 1'b0; WB_flush = 1'b0;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      chk("rst_we",      {31'd0, REG_write_1}, 32'd0);
      chk("rst_data",    REG_data_wb_in1, 32'd0);
      chk("rst_retired", WB_retired, 32'd0);

      clk_reset = 1'b0;
      op(1'b1, 1'b1, 5'd3, 2'd0, 3'd0, 2'd0, 32'h0000_1234, 32'd0, 32'd0);
      chk("alu_we",   {31'd0, REG_write_1}, 32'd1);
      chk("alu_addr", {27'd0, REG_address_wr}, 32'd3);
      chk("alu_data", REG_data_wb_in1, 32'h0000_1234);
      op(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0, 32'd0, 32'd0, 32'd0);
      chk("alu_retired", WB_retired, 32'd1);

      ld(3'd3, 2'd1, 32'hFFFF_FFF1, "lb_off1");
      ld(3'd4, 2'd1, 32'h0000_00F1, "lbu_off1");
      ld(3'd1, 2'd0, 32'hFFFF_80F1, "lh_off0");
      ld(3'd2, 2'd2, 32'h0000_7F22, "lhu_off2");
      ld(3'd0, 2'd0, 32'h80F1_7F22, "lw_off0");

      op(1'b1, 1'b1, 5'd4, 2'd1, 3'd0, 2'd2, 32'd0, 32'h80F1_7F22, 32'd0);
      chk("lw2_we",  {31'd0, REG_write_1}, 32'd0);
      chk("lw2_err", {31'd0, WB_align_err}, 32'd1);
      op(1'b1, 1'b1, 5'd4, 2'd1, 3'd1, 2'd3, 32'd0, 32'h80F1_7F22, 32'd0);
      chk("lh3_we",  {31'd0, REG_write_1}, 32'd0);
      chk("lh3_err", {31'd0, WB_align_err}, 32'd1);
      op(1'b1, 1'b1, 5'd4, 2'd1, 3'd5, 2'd0, 32'd0, 32'h80F1_7F22, 32'd0);
      chk("rsvd_lt_err", {31'd0, WB_align_err}, 32'd1);
      op(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0, 32'd0, 32'd0, 32'd0);
      chk("bubble_err", {31'd0, WB_align_err}, 32'd0);

      op(1'b1, 1'b1, 5'd31, 2'd2, 3'd0, 2'd0, 32'd0, 32'd0, 32'hFFFF_FFFC);
      chk("link_data", REG_data_wb_in1, 32'h0000_0004);
      chk("link_addr", {27'd0, REG_address_wr}, 32'd31);
      op(1'b1, 1'b1, 5'd0, 2'd2, 3'd0, 2'd0, 32'd0, 32'd0, 32'hFFFF_FFFC);
      chk("r0_we",   {31'd0, REG_write_1}, 32'd0);
      chk("r0_data", REG_data_wb_in1, 32'd0);
      op(1'b1, 1'b1, 5'd7, 2'd3, 3'd0, 2'd0, 32'h1111_1111, 32'd0, 32'd0);
      chk("sel3_we", {31'd0, REG_write_1}, 32'd0);

      op(1'b1, 1'b1, 5'd5, 2'd0, 3'd0, 2'd0, 32'h0000_0055, 32'd0, 32'd0);
      MEM_rd = 5'd9; MEM_alu_result = 32'h0000_00AA; WB_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_data", REG_data_wb_in1, 32'h0000_0055);
         chk("stall_addr", {27'd0, REG_address_wr}, 32'd5);
      end
      WB_flush = 1'b1;
      @(negedge clk);
      chk("stflush_we", {31'd0, REG_write_1}, 32'd0);

      for (int i = 0; i < 20; i++) begin
         op(1'b1, 1'b1, 5'd1 + 5'(i % 30), 2'd0, 3'd0, 2'd0, 32'(i), 32'd0, 32'd0);
         if (m_cnt != 0 && (m_cnt & 32'hF) == 32'd0)
            chk("wrap4", {28'd0, w4_retired}, 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_writeback_stage
